// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the single-port memory arbiter: bus words, fetch epochs,
// data-side access kinds and the read-response owner.
package mem_port_arbiter_pkg;

   typedef logic [31:0] rvwordT;
   typedef logic [2:0]  EpochT;

   localparam EpochT EPOCH_INVALID = 3'd0;

   typedef enum logic [1:0] {
      MEM_NONE  = 2'd0,
      MEM_READ  = 2'd1,
      MEM_WRITE = 2'd2
   } MemControlT;

   typedef enum logic [1:0] {
      R_NONE  = 2'd0,
      R_FETCH = 2'd1,
      R_DATA  = 2'd2
   } RespOwnerT;

   localparam int MEM_ADDR_W           = 16;
   localparam int MAX_DATA_STREAK_DFLT = 3;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data traffic onto one single-port, 1-cycle-latency RAM.
// Data wins by default; a data-grant streak counter forces fetch through.
//
// resp_owner | meaning
// R_NONE     | no read response due this cycle
// R_FETCH    | m_rdata belongs to the fetch unit
// R_DATA     | m_rdata belongs to the execute unit
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W          = MEM_ADDR_W,
   parameter int MAX_DATA_STREAK = MAX_DATA_STREAK_DFLT,
   parameter int STREAK_W        = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  rvwordT            i_addr,
   input  EpochT             i_epoch,
   output logic              i_gnt,
   output logic              i_rvalid,
   output rvwordT            i_rdata,
   output EpochT             i_repoch,
   input  MemControlT        d_control,
   input  rvwordT            d_addr,
   input  rvwordT            d_wdata,
   input  logic [3:0]        d_be,
   output logic              d_gnt,
   output logic              d_rvalid,
   output rvwordT            d_rdata,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_wdata,
   output logic [3:0]        m_be,
   input  logic [31:0]       m_rdata
);

   localparam logic [STREAK_W-1:0] L_STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

   RespOwnerT           r_resp_owner;
   EpochT               r_resp_epoch;
   logic [STREAK_W-1:0] r_streak;

   logic w_d_req;
   logic w_i_gnt;
   logic w_d_gnt;
   logic w_unused_addr;

   // Byte offset and bits beyond the RAM depth are intentionally dropped.
   assign w_unused_addr = ^{i_addr[1:0], i_addr[31:ADDR_W+2],
                            d_addr[1:0], d_addr[31:ADDR_W+2]};

   always_comb begin
      w_d_req = (d_control != MEM_NONE);
      w_i_gnt = 1'b0;
      w_d_gnt = 1'b0;
      if (!rst) begin
         if (i_req && (r_streak == L_STREAK_MAX)) begin
            w_i_gnt = 1'b1;
         end else if (w_d_req) begin
            w_d_gnt = 1'b1;
         end else if (i_req) begin
            w_i_gnt = 1'b1;
         end
      end

      m_en    = w_i_gnt | w_d_gnt;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_be    = '0;
      if (w_i_gnt) begin
         m_addr = i_addr[ADDR_W+1:2];
         m_be   = 4'hF;
      end else if (w_d_gnt) begin
         m_we    = (d_control == MEM_WRITE);
         m_addr  = d_addr[ADDR_W+1:2];
         m_wdata = d_wdata;
         m_be    = d_be;
      end
   end

   assign i_gnt = w_i_gnt;
   assign d_gnt = w_d_gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_resp_owner <= R_NONE;
         r_resp_epoch <= EPOCH_INVALID;
         r_streak     <= '0;
      end else begin
         if (w_i_gnt) begin
            r_resp_owner <= R_FETCH;
            r_resp_epoch <= i_epoch;
         end else if (w_d_gnt && (d_control == MEM_READ)) begin
            r_resp_owner <= R_DATA;
         end else begin
            r_resp_owner <= R_NONE;
         end

         if (w_i_gnt || !i_req) begin
            r_streak <= '0;
         end else if (w_d_gnt && (r_streak != L_STREAK_MAX)) begin
            r_streak <= r_streak + STREAK_W'(1);
         end
      end
   end

   // A response still owed when reset arrives is suppressed, not delivered.
   assign i_rvalid = (r_resp_owner == R_FETCH) && !rst;
   assign d_rvalid = (r_resp_owner == R_DATA) && !rst;
   assign i_rdata  = i_rvalid ? m_rdata : '0;
   assign d_rdata  = d_rvalid ? m_rdata : '0;
   assign i_repoch = r_resp_epoch;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a behavioural memory and a
// transaction-level reference model of grants, writes and read responses.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int ADDR_W = 16;
   localparam int MAXS   = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   rvwordT      i_addr;
   EpochT       i_epoch;
   logic        i_gnt;
   logic        i_rvalid;
   rvwordT      i_rdata;
   EpochT       i_repoch;
   MemControlT  d_control;
   rvwordT      d_addr;
   rvwordT      d_wdata;
   logic [3:0]  d_be;
   logic        d_gnt;
   logic        d_rvalid;
   rvwordT      d_rdata;
   logic        m_en;
   logic        m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   logic [31:0] m_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_DATA_STREAK(MAXS), .STREAK_W(2)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_epoch(i_epoch), .i_gnt(i_gnt),
      .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_repoch(i_repoch),
      .d_control(d_control), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_be(m_be), .m_rdata(m_rdata)
   );

   function automatic logic [31:0] init_word(input logic [15:0] a);
      return {a, ~a} ^ 32'h5A5A_3C3C;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   // Environment RAM: one-cycle read latency, junk on the bus when idle.
   logic [31:0] env_mem [0:65535];
   bit          env_wr  [0:65535];
   always @(posedge clk) begin
      if (m_en && !m_we) m_rdata <= env_wr[m_addr] ? env_mem[m_addr] : init_word(m_addr);
      else               m_rdata <= $urandom;
      if (m_en && m_we) begin
         env_mem[m_addr] <= merge(env_wr[m_addr] ? env_mem[m_addr] : init_word(m_addr),
                                  m_wdata, m_be);
         env_wr[m_addr]  <= 1'b1;
      end
   end

   // Reference model state
   logic [31:0] ref_mem [0:65535];
   bit          ref_wr  [0:65535];
   int          run;
   int          exp_resp;
   logic [31:0] exp_rd;
   EpochT       exp_repoch;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_read(input logic [15:0] a);
      return ref_wr[a] ? ref_mem[a] : init_word(a);
   endfunction

   // Check one cycle against the model, then advance the model over the edge.
   task automatic cycle(output logic gi, output logic gd);
      logic        dreq, eg_i, eg_d, ev_i, ev_d, is_wr;
      logic [15:0] wa_i, wa_d;
      #2;
      dreq  = (d_control != MEM_NONE);
      is_wr = (d_control == MEM_WRITE);
      wa_i  = i_addr[ADDR_W+1:2];
      wa_d  = d_addr[ADDR_W+1:2];
      eg_i  = 1'b0;
      eg_d  = 1'b0;
      if (!rst) begin
         if (i_req && run == MAXS) eg_i = 1'b1;
         else if (dreq)            eg_d = 1'b1;
         else if (i_req)           eg_i = 1'b1;
      end
      chk("i_gnt", i_gnt, eg_i);
      chk("d_gnt", d_gnt, eg_d);
      chk("m_en",  m_en, eg_i | eg_d);
      chk("m_we",  m_we, eg_d & is_wr);
      if (eg_i) begin
         chk("m_addr_f",  m_addr, wa_i);
         chk("m_be_f",    m_be, 4'hF);
         chk("m_wdata_f", m_wdata, 0);
      end else if (eg_d) begin
         chk("m_addr_d", m_addr, wa_d);
         if (is_wr) begin
            chk("m_wdata_d", m_wdata, d_wdata);
            chk("m_be_d",    m_be, d_be);
         end
      end else begin
         chk("m_addr_idle",  m_addr, 0);
         chk("m_wdata_idle", m_wdata, 0);
         chk("m_be_idle",    m_be, 0);
      end
      ev_i = (exp_resp == 1) && !rst;
      ev_d = (exp_resp == 2) && !rst;
      chk("i_rvalid", i_rvalid, ev_i);
      chk("d_rvalid", d_rvalid, ev_d);
      chk("i_rdata",  i_rdata, ev_i ? exp_rd : 32'h0);
      chk("d_rdata",  d_rdata, ev_d ? exp_rd : 32'h0);
      chk("i_repoch", i_repoch, exp_repoch);
      gi = i_gnt;
      gd = d_gnt;
      @(posedge clk);
      if (rst) begin
         exp_resp   = 0;
         exp_repoch = EPOCH_INVALID;
         run        = 0;
      end else begin
         exp_resp = 0;
         if (eg_i) begin
            exp_resp   = 1;
            exp_rd     = ref_read(wa_i);
            exp_repoch = i_epoch;
         end else if (eg_d && !is_wr) begin
            exp_resp = 2;
            exp_rd   = ref_read(wa_d);
         end else if (eg_d) begin
            ref_mem[wa_d] = merge(ref_read(wa_d), d_wdata, d_be);
            ref_wr[wa_d]  = 1'b1;
         end
         if (eg_i || !i_req) run = 0;
         else if (eg_d && run < MAXS) run = run + 1;
      end
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic gi, gd;
      logic [11:0] pat;
      logic [31:0] rnd;
      run        = 0;
      exp_resp   = 0;
      exp_rd     = '0;
      exp_repoch = EPOCH_INVALID;
      rst        = 1'b1;
      i_req      = 1'b1;
      i_addr     = 32'h10;
      i_epoch    = 3'd1;
      d_control  = MEM_READ;
      d_addr     = 32'h40;
      d_wdata    = '0;
      d_be       = 4'hF;
      @(posedge clk);
      @(negedge clk);

      // 1: reset holds grants off, data wins on release
      cycle(gi, gd);
      cycle(gi, gd);
      rst = 1'b0;
      cycle(gi, gd);
      chk("t1_first_dgnt", gd, 1);

      // 2: fetch alone
      d_control = MEM_NONE;
      cycle(gi, gd);
      chk("t2_fgnt", gi, 1);
      i_req = 1'b0;
      #2;
      chk("t2_rvalid", i_rvalid, 1);
      chk("t2_repoch", i_repoch, 3'd1);
      chk("t2_rdata",  i_rdata, init_word(16'd4));
      cycle(gi, gd);

      // 3: write then read back
      d_control = MEM_WRITE; d_addr = 32'h20; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
      cycle(gi, gd);
      d_control = MEM_READ;
      cycle(gi, gd);
      d_control = MEM_NONE;
      #2;
      chk("t3_rdata", d_rdata, 32'hDEADBEEF);
      cycle(gi, gd);

      // 4: starvation guard, fetch every fourth slot
      i_req = 1'b1; i_addr = 32'h100; i_epoch = 3'd5;
      d_control = MEM_READ;
      pat = '0;
      for (int k = 0; k < 12; k++) begin
         d_addr = 32'(k) << 2;
         cycle(gi, gd);
         pat[k] = gi;
      end
      chk("t4_pattern", pat, 12'h888);

      // 5: simultaneous fresh requests
      i_req = 1'b0; d_control = MEM_NONE;
      cycle(gi, gd);
      i_req = 1'b1; i_epoch = 3'd2; d_control = MEM_READ; d_addr = 32'h20;
      cycle(gi, gd);
      chk("t5_data_first", gd, 1);
      d_control = MEM_NONE;
      cycle(gi, gd);
      chk("t5_fetch_next", gi, 1);
      i_req = 1'b0;
      cycle(gi, gd);

      // 6: reset while a fetch read is in flight
      i_req = 1'b1; i_epoch = 3'd6; i_addr = 32'h44;
      cycle(gi, gd);
      i_req = 1'b0; rst = 1'b1;
      #2;
      chk("t6_rvalid_rst", i_rvalid, 0);
      cycle(gi, gd);
      rst = 1'b0;
      cycle(gi, gd);
      chk("t6_repoch", i_repoch, EPOCH_INVALID);

      // Random traffic with requests held until granted
      gi = 1'b1; gd = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         if (gi || !i_req) begin
            i_req  = ($urandom_range(0, 99) < 60);
            rnd    = $urandom;
            i_addr = {rnd[31:8], 8'($urandom_range(0, 63)) << 2};
            i_epoch = EpochT'($urandom_range(0, 7));
         end else if ($urandom_range(0, 7) == 0) begin
            i_epoch = EpochT'($urandom_range(0, 7));
         end
         if (gd || d_control == MEM_NONE) begin
            case ($urandom_range(0, 3))
               0:       d_control = MEM_NONE;
               1:       d_control = MEM_WRITE;
               default: d_control = MEM_READ;
            endcase
            rnd     = $urandom;
            d_addr  = {rnd[31:8], 8'($urandom_range(0, 63)) << 2};
            d_wdata = $urandom;
            d_be    = 4'($urandom_range(0, 15));
         end
         rst = ($urandom_range(0, 199) == 0);
         cycle(gi, gd);
         if (rst) begin
            gi = 1'b1; gd = 1'b1;
         end
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
